// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris input front end:
// key indices, repeat-FSM states and 50 MHz timing defaults.
package tetris_pkg;

  localparam int KEY_LEFT  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_ROT   = 2;

  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_REPEAT_DELAY    = 10_000_000;
  localparam int DEF_REPEAT_RATE     = 2_500_000;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One raw active-low button: synchroniser, debounce filter,
// debounced active-high level and registered press edge.
module key_debouncer
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    vld_q;
  logic          stable_q;
  logic          press_q;
  logic          arm_q;
  logic [CW-1:0] cnt_q;
  logic          sample;
  logic          flip;

  assign sample = ~sync2_q;
  assign flip   = (sample != stable_q) && (cnt_q == LAST);

  // A key held through reset must be seen released before it may press.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      vld_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      arm_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= key_n_raw;
      sync2_q <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      press_q <= flip & ~stable_q & arm_q;
      if (vld_q[1] && !sample && !stable_q) begin
        arm_q <= 1'b1;
      end
      if (sample == stable_q) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q    <= '0;
        stable_q <= sample;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/input_conditioner.sv
// Button front end for the game FSM: debounced keys, lateral
// auto-repeat, and a priority arbiter emitting one pulse per cycle.
module input_conditioner
  import tetris_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic       left_final,
  output logic       right_final,
  output logic       rot_final,
  output logic [2:0] key_level
);

  localparam int CW =
    $clog2(imax(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  logic [2:0]    level;
  logic [2:0]    press;
  logic [2:0]    req;
  logic [2:0]    grant;
  logic [2:0]    pend_q;
  logic [2:0]    pend_d;
  logic [2:0]    fin_q;
  logic          both;
  rpt_state_e    st_q  [2];
  rpt_state_e    st_d  [2];
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  for (genvar g = 0; g < 3; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .key_n_raw(key_n[g]),
      .level    (level[g]),
      .press    (press[g])
    );
  end

  // Left and right held together cancel each other entirely.
  always_comb begin
    both = level[KEY_LEFT] & level[KEY_RIGHT];
    req  = '0;
    req[KEY_ROT] = press[KEY_ROT];
    for (int i = 0; i < 2; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (both) begin
        st_d[i]  = RPT_IDLE;
        cnt_d[i] = '0;
      end else begin
        unique case (st_q[i])
          RPT_IDLE: begin
            if (press[i]) begin
              req[i]   = 1'b1;
              cnt_d[i] = '0;
              st_d[i]  = RPT_DELAY;
            end
          end
          RPT_DELAY: begin
            if (!level[i]) begin
              st_d[i]  = RPT_IDLE;
              cnt_d[i] = '0;
            end else if (cnt_q[i] == DLY_LAST) begin
              req[i]   = 1'b1;
              cnt_d[i] = '0;
              st_d[i]  = RPT_REPEAT;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          RPT_REPEAT: begin
            if (!level[i]) begin
              st_d[i]  = RPT_IDLE;
              cnt_d[i] = '0;
            end else if (cnt_q[i] == RATE_LAST) begin
              req[i]   = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
          default: begin
            st_d[i]  = RPT_IDLE;
            cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    grant = '0;
    priority case (1'b1)
      pend_q[KEY_ROT]:   grant[KEY_ROT]   = 1'b1;
      pend_q[KEY_LEFT]:  grant[KEY_LEFT]  = 1'b1;
      pend_q[KEY_RIGHT]: grant[KEY_RIGHT] = 1'b1;
      default:           grant = '0;
    endcase
    pend_d = (pend_q & ~grant) | req;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      st_q   <= '{RPT_IDLE, RPT_IDLE};
      cnt_q  <= '{default: '0};
      pend_q <= '0;
      fin_q  <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      fin_q  <= grant;
    end
  end

  assign left_final  = fin_q[KEY_LEFT];
  assign right_final = fin_q[KEY_RIGHT];
  assign rot_final   = fin_q[KEY_ROT];
  assign key_level   = level;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: schedule-based reference model
// compared every cycle, plus hand-computed pulse timings.
module tb_input_conditioner;
  import tetris_pkg::*;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       left_final;
  logic       right_final;
  logic       rot_final;
  logic [2:0] key_level;

  input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .key_n      (key_n),
    .left_final (left_final),
    .right_final(right_final),
    .rot_final  (rot_final),
    .key_level  (key_level)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int lq[$];
  int rq[$];
  int oq[$];

  // reference model state
  int          k;
  logic [2:0]  h1, h2, stab, armd, pend, reqp, efin;
  logic [DB-1:0] w [3];
  int          nw [3];
  bit          act [2];
  int          tp [2];

  task automatic chk(input string nm, input int act_v, input int exp_v);
    tests++;
    if (act_v != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act_v, exp_v, cyc);
    end
  endtask

  function automatic int n_in(input int q[$], input int a, input int b);
    int n = 0;
    foreach (q[i]) if (q[i] >= a && q[i] <= b) n++;
    return n;
  endfunction

  function automatic int first_at(input int q[$], input int a);
    foreach (q[i]) if (q[i] >= a) return q[i];
    return -1;
  endfunction

  task automatic model_reset();
    k = 0; h1 = '1; h2 = '1;
    stab = '0; armd = '0; pend = '0; reqp = '0; efin = '0;
    for (int i = 0; i < 3; i++) begin w[i] = '0; nw[i] = 0; end
    for (int i = 0; i < 2; i++) begin act[i] = 0; tp[i] = 0; end
  endtask

  // One clock edge: arbiter output, debounce windows, then requests.
  task automatic model_step();
    logic [2:0] pr, rqv, s;
    bit both;
    int d;
    efin = '0;
    if (pend[KEY_ROT]) efin[KEY_ROT] = 1'b1;
    else if (pend[KEY_LEFT]) efin[KEY_LEFT] = 1'b1;
    else if (pend[KEY_RIGHT]) efin[KEY_RIGHT] = 1'b1;
    pend = (pend & ~efin) | reqp;
    pr = '0;
    for (int i = 0; i < 3; i++) begin
      s[i] = (k >= 2) ? ~h2[i] : 1'b0;
      w[i] = {w[i][DB-2:0], s[i]};
      if (nw[i] < DB) nw[i]++;
      if (nw[i] == DB && w[i] == {DB{~stab[i]}}) begin
        pr[i] = ~stab[i] & armd[i];
        stab[i] = ~stab[i];
      end else if (k >= 2 && !s[i] && !stab[i]) begin
        armd[i] = 1'b1;
      end
    end
    h2 = h1;
    h1 = key_n;
    rqv = '0;
    both = stab[KEY_LEFT] && stab[KEY_RIGHT];
    for (int i = 0; i < 2; i++) begin
      if (pr[i] && !both) begin act[i] = 1; tp[i] = k; end
      if (both || !stab[i]) act[i] = 0;
      else if (act[i]) begin
        d = k - tp[i];
        if (d == 0 || d == RD || (d > RD && (d - RD) % RR == 0))
          rqv[i] = 1'b1;
      end
    end
    rqv[KEY_ROT] = pr[KEY_ROT];
    reqp = rqv;
    k++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLOCK_50);
      cyc++;
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(posedge CLOCK_50);
      #1;
      chk("outputs", {rot_final, right_final, left_final}, efin);
      chk("key_level", key_level, stab);
      chk("exclusive",
          int'($countones({rot_final, right_final, left_final}) <= 1), 1);
      if (left_final)  lq.push_back(cyc);
      if (right_final) rq.push_back(cyc);
      if (rot_final)   oq.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic drive(input logic [2:0] v, output int e);
    @(negedge CLOCK_50);
    key_n = v;
    e = cyc + 1;
  endtask

  int b0, s0, r0, p0, e0, l0, rp, q0, m0, z0, v0, tmp;

  initial begin
    reset = 1'b1;
    key_n = 3'b111;
    step(3);
    chk("rst_left", left_final, 0);
    chk("rst_right", right_final, 0);
    chk("rst_rot", rot_final, 0);
    chk("rst_level", key_level, 0);
    reset = 1'b0;
    step(8);

    // bounce then settle on left
    b0 = cyc + 1;
    for (int j = 0; j < 20; j++) begin
      @(negedge CLOCK_50);
      key_n[0] = ((j / 2) % 2 != 0) ? 1'b1 : 1'b0;
    end
    drive(3'b110, s0);
    step(47);
    chk("bounce_quiet", n_in(lq, b0, s0 + 6), 0);
    chk("first_left", first_at(lq, s0), s0 + 7);
    chk("rpt_delay", first_at(lq, s0 + 8), s0 + 17);
    chk("rpt_rate1", first_at(lq, s0 + 18), s0 + 20);
    chk("rpt_rate2", first_at(lq, s0 + 21), s0 + 23);
    chk("held_level", key_level[0], 1);
    drive(3'b111, r0);
    step(30);
    chk("release_quiet", n_in(lq, r0 + 7, r0 + 30), 0);

    // rotate: one pulse per press
    drive(3'b011, p0);
    step(100);
    chk("rot_once", n_in(oq, p0, p0 + 100), 1);
    chk("rot_latency", first_at(oq, p0), p0 + 7);
    drive(3'b111, tmp);
    step(12);
    drive(3'b011, p0);
    step(30);
    chk("rot_again", n_in(oq, p0, p0 + 30), 1);
    drive(3'b111, tmp);
    step(12);

    // rotate beats left
    drive(3'b010, e0);
    step(10);
    chk("arb_rot", first_at(oq, e0), e0 + 7);
    chk("arb_left", first_at(lq, e0), e0 + 8);
    drive(3'b111, tmp);
    step(20);

    // opposing hold
    drive(3'b110, l0);
    step(25);
    drive(3'b100, rp);
    step(25);
    chk("opp_stop",
        n_in(lq, rp + 7, rp + 25) + n_in(rq, rp, rp + 25), 0);
    drive(3'b110, q0);
    step(30);
    chk("opp_noresume", n_in(lq, q0, q0 + 30), 0);
    chk("opp_level", key_level, 1);
    drive(3'b111, tmp);
    step(12);
    drive(3'b110, l0);
    step(10);
    chk("repress", first_at(lq, l0), l0 + 7);
    drive(3'b111, tmp);
    step(15);

    // reset while left pending in DELAY
    drive(3'b110, m0);
    step(7);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {rot_final, right_final, left_final}, 0);
    chk("mid_rst_level", key_level, 0);
    step(3);
    reset = 1'b0;
    z0 = cyc + 1;
    step(30);
    chk("rst_nopulse", n_in(lq, m0, z0 + 30), 0);
    chk("rst_held_level", key_level[0], 1);
    drive(3'b111, tmp);
    step(12);
    drive(3'b110, v0);
    step(10);
    chk("rst_repress", first_at(lq, v0), v0 + 7);
    drive(3'b111, tmp);
    step(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage directly upstream of the Tetris game-logic FSM.
- Turns the three raw, bouncing, active-low push-buttons (left, right, rotate) into the clean single-cycle action pulses left_final, right_final and rot_final that game logic consumes.
- Provides synchronisation, debounce, press-edge detection and hold-to-repeat (delayed auto-shift) for left/right.
- Guarantees at most one action pulse per clock cycle.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz).
- REPEAT_DELAY, 10000000: hold time before the first auto-repeat of left/right (200 ms).
- REPEAT_RATE, 2500000: period between subsequent auto-repeats (50 ms).

Ports:
- CLOCK_50 in 1: system clock, 50 MHz.
- reset in 1: asynchronous, active-high reset.
- key_n in 3: raw buttons, active-low, asynchronous; bit0=left, bit1=right, bit2=rotate.
- left_final out 1: one-cycle move-left request.
- right_final out 1: one-cycle move-right request.
- rot_final out 1: one-cycle rotate request.
- key_level out 3: debounced active-high button levels, same bit order, for LEDs/debug.

Behaviour:
- Reset: asynchronous assert, synchronous release.
  - All outputs 0, all counters 0, all pending flags 0, all repeat FSMs IDLE.
  - Synchroniser flops reset to 1 (released button).
- Per key, in the sub-module:
  - 2-flop synchroniser, then invert to active-high.
  - Sample equals stable level: counter clears.
  - Sample differs from stable level: counter increments.
  - Stable flips when the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present; counter then clears.
  - key_level = stable levels.
- Press edge: stable 0->1, registered.
  - With a constant-low key_n from cycle 0 and no contention, the first action pulse is asserted exactly DEBOUNCE_CYCLES+3 cycles later.
  - Release edges never generate pulses.
- Rotate: exactly one request per press, no repeat.
- Left and right each have a repeat FSM with states IDLE, DELAY, REPEAT and a shared-width counter sized $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - IDLE: on press edge, raise request, counter=0, go to DELAY.
  - DELAY: counter increments; at REPEAT_DELAY-1, raise request, clear counter, go to REPEAT.
  - REPEAT: counter increments; at REPEAT_RATE-1, raise request, clear counter, stay.
  - From DELAY or REPEAT, a debounced release goes to IDLE the next cycle. A request due in that same cycle is dropped.
- Opposing hold: while both left and right stable levels are 1, both FSMs are forced to IDLE and no lateral requests are raised.
  - When one is released, the other does not restart repeating until it is re-pressed.
  - Two press edges in the same cycle cancel each other.
- Arbitration:
  - Each request sets a pending flag.
  - Each cycle the highest-priority pending flag (rot > left > right) is emitted on its *_final output and cleared.
  - Others stay pending. A new request on an already-pending flag is merged (not counted twice).
  - The outputs are registered and mutually exclusive.
- Reset mid-operation: pending requests and partial counts are discarded. No pulse appears in the cycle reset deasserts.
- Counter wrap: impossible by construction. Counters always clear at their terminal value.

Decomposition:
- Shared package tetris_pkg:
  - key index constants KEY_LEFT=0, KEY_RIGHT=1, KEY_ROT=2.
  - repeat-state enum {RPT_IDLE, RPT_DELAY, RPT_REPEAT}.
  - default timing constants for 50 MHz.
- One sub-module, key_debouncer (parameter DEBOUNCE_CYCLES; ports CLOCK_50, reset, key_n_raw, level, press), instantiated 3×.
- The repeat FSMs and the arbiter stay in input_conditioner.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Bounce: key_n[0] toggles 1/0 every 2 cycles for 20 cycles, then holds 0 -> no pulse during the bounce; exactly one left_final 7 cycles after the final settle; key_level[0]=1.
- Auto-repeat: hold left 40 cycles after acceptance -> left_final at t0, t0+10, t0+13, t0+16, …; after release and debounce, no further pulses.
- Rotate hold: key_n[2]=0 for 100 cycles -> exactly one rot_final. A release/press after that gives exactly one more.
- Arbitration: left and rotate driven low in the same cycle -> rot_final at cycle N, left_final at N+1, never both high.
- Opposing hold: left held in REPEAT, then right pressed -> lateral pulses stop once both are accepted. Release right -> no left pulses until left is re-pressed.
- Reset mid-operation: assert reset during DELAY with left pending -> all outputs 0 immediately and no pulse after release, even with key_n still 0 (the key must be released and re-pressed).
